// File: rtl/debug_responder.sv
// debug_responder: debug-bus register target (CMD/ADDR/DATA/STATUS) that runs halt/run/step/GPR/memory commands on the core.
// Latency: register reads 1 clk; RUN/NOP/WR_REG/error commands ack 1 clk after req, the rest once the core responds.
// Backpressure: req is held until the one-cycle ack; DEBUG_TIMEOUT_EN bounds every wait state at TIMEOUT_CYCLES.
module debug_responder #(
    parameter int REG_SEL_W      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           addr,
    input  logic [31:0]          write_data,
    input  logic                 wr_en,
    input  logic                 req,
    output logic [31:0]          read_data,
    output logic                 ack,
    output logic                 cpu_halt_req,
    input  logic                 cpu_halted,
    output logic                 cpu_step,
    input  logic                 cpu_step_done,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_rd_en,
    input  logic [31:0]          reg_rd_val,
    output logic                 reg_wr_en,
    output logic [31:0]          reg_wr_val,
    output logic                 mem_req,
    output logic                 mem_wr_en,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wr_data,
    input  logic [31:0]          mem_rd_data,
    input  logic                 mem_ack
);
    typedef enum logic [2:0] {IDLE, HALT_WAIT, STEP_WAIT, REG_RD, MEM_WAIT, DONE} state_t;

    localparam logic [2:0] CMD_HALT   = 3'd0;
    localparam logic [2:0] CMD_RUN    = 3'd1;
    localparam logic [2:0] CMD_STEP   = 3'd2;
    localparam logic [2:0] CMD_RD_REG = 3'd3;
    localparam logic [2:0] CMD_WR_REG = 3'd4;
    localparam logic [2:0] CMD_RD_MEM = 3'd5;
    localparam logic [2:0] CMD_WR_MEM = 3'd6;
    localparam logic [2:0] CMD_NOP    = 3'd7;

    state_t      state;
    logic [31:0] cmd_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        err_nothalt;
    logic        err_timeout;
    logic [31:0] status;
    logic [31:0] rd_mux;
    logic        timeout;
    logic [2:0]  op;

    assign op          = cmd_q[2:0];
    assign status      = {28'b0, err_nothalt, err_timeout, state != IDLE, cpu_halted};
    assign ack         = (state == DONE);
    assign reg_sel     = addr_q[REG_SEL_W-1:0];
    assign reg_wr_val  = data_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = data_q;

`ifdef DEBUG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;

    assign in_wait = (state == HALT_WAIT) || (state == STEP_WAIT) || (state == MEM_WAIT);
    // Count starts at 0 on wait-state entry, so the limit hits on the TIMEOUT_CYCLES-th wait cycle.
    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    logic [31:0] unused_timeout_cfg;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        rd_mux = '0;
        case (addr)
            2'd0:    rd_mux = cmd_q;
            2'd1:    rd_mux = addr_q;
            2'd2:    rd_mux = data_q;
            default: rd_mux = status;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            err_nothalt  <= 1'b0;
            err_timeout  <= 1'b0;
            read_data    <= '0;
            cpu_halt_req <= 1'b0;
            cpu_step     <= 1'b0;
            reg_rd_en    <= 1'b0;
            reg_wr_en    <= 1'b0;
            mem_req      <= 1'b0;
            mem_wr_en    <= 1'b0;
        end else begin
            read_data <= rd_mux;
            cpu_step  <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        case (addr)
                            2'd0: begin
                                cmd_q       <= write_data;
                                err_nothalt <= 1'b0;
                                err_timeout <= 1'b0;
                            end
                            2'd1:    addr_q <= write_data;
                            2'd2:    data_q <= write_data;
                            default: ;
                        endcase
                    end
                    // Decode uses the CMD already latched; a same-cycle CMD write applies to the next req.
                    if (req) begin
                        state <= DONE;
                        case (op)
                            CMD_HALT: begin
                                cpu_halt_req <= 1'b1;
                                state        <= HALT_WAIT;
                            end
                            CMD_RUN: cpu_halt_req <= 1'b0;
                            CMD_STEP, CMD_RD_REG, CMD_WR_REG: begin
                                if (!cpu_halted) begin
                                    err_nothalt <= 1'b1;
                                end else if (op == CMD_STEP) begin
                                    cpu_step <= 1'b1;
                                    state    <= STEP_WAIT;
                                end else if (op == CMD_RD_REG) begin
                                    reg_rd_en <= 1'b1;
                                    state     <= REG_RD;
                                end else begin
                                    reg_wr_en <= 1'b1;
                                end
                            end
                            CMD_RD_MEM, CMD_WR_MEM: begin
                                mem_req   <= 1'b1;
                                mem_wr_en <= (op == CMD_WR_MEM);
                                state     <= MEM_WAIT;
                            end
                            CMD_NOP: ;
                            default: ;
                        endcase
                    end
                end
                HALT_WAIT: begin
                    if (cpu_halted) begin
                        state <= DONE;
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= DONE;
                    end
                end
                STEP_WAIT: begin
                    if (cpu_step_done) begin
                        state <= DONE;
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        state       <= DONE;
                    end
                end
                REG_RD: begin
                    data_q <= reg_rd_val;
                    state  <= DONE;
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        if (!mem_wr_en) data_q <= mem_rd_data;
                        mem_req   <= 1'b0;
                        mem_wr_en <= 1'b0;
                        state     <= DONE;
                    end else if (timeout) begin
                        err_timeout <= 1'b1;
                        mem_req     <= 1'b0;
                        mem_wr_en   <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
